// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: strobed, one-shot command stage in front of the 4-bit ALU.
// It synchronises the asynchronous load strobe and captures the operands and opcode.
// It then issues one ALU operation and registers the result, the status flags and an operation count.
// Optional feature macro: ALU_SEQ_CHAIN_EN.
// When ALU_SEQ_CHAIN_EN is defined, data_in[3:0]==4'hF with op_in[2] set reuses result_q[3:0] as operand a.
module alu_op_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             strobe_in,
  input  logic [7:0]       data_in,
  input  logic [2:0]       op_in,
  input  logic             clr_in,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_sel,
  input  logic [7:0]       alu_result,
  output logic             op_valid,
  output logic             res_valid,
  output logic [7:0]       result_q,
  output logic             busy,
  output logic             div_zero,
  output logic             overrun,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DONE  = 2'b10
  } state_t;

  state_t               state_r;
  state_t               next_state_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                 edge_r;
  logic                 rise_s;
  logic                 capture_s;
  logic                 latch_res_s;
  logic                 count_s;
  logic                 drop_s;
  logic [3:0]           a_r;
  logic [3:0]           b_r;
  logic [2:0]           sel_r;
  logic [3:0]           a_next_s;
  logic [7:0]           result_r;
  logic                 div_zero_r;
  logic                 op_valid_r;
  logic                 res_valid_r;
  logic                 busy_r;
  logic                 overrun_r;
  logic [CNT_W-1:0]     op_count_r;

  // One pulse per low-to-high transition of the synchronised strobe.
  assign rise_s = sync_r[SYNC_STAGES-1] & ~edge_r;

  // Strobe synchroniser chain plus the edge-detect flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
      edge_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], strobe_in};
      edge_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode and per-state datapath enables.
  always_comb begin
    next_state_s = state_r;
    capture_s    = 1'b0;
    latch_res_s  = 1'b0;
    count_s      = 1'b0;
    drop_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (rise_s) begin
          capture_s    = 1'b1;
          next_state_s = ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        latch_res_s  = 1'b1;
        drop_s       = rise_s;
        next_state_s = DONE;
      end
      DONE: begin
        count_s      = 1'b1;
        drop_s       = rise_s;
        next_state_s = IDLE;
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Operand a source: pads normally, the previous result in chain mode.
  always_comb begin
    a_next_s = data_in[3:0];
`ifdef ALU_SEQ_CHAIN_EN
    if ((data_in[3:0] == 4'hF) && op_in[2]) begin
      a_next_s = result_r[3:0];
    end else begin
      a_next_s = data_in[3:0];
    end
`endif
  end

  // Operand registers: loaded only on an accepted strobe, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= 4'h0;
      b_r   <= 4'h0;
      sel_r <= 3'b000;
    end else if (capture_s) begin
      a_r   <= a_next_s;
      b_r   <= data_in[7:4];
      sel_r <= op_in;
    end else begin
      a_r   <= a_r;
      b_r   <= b_r;
      sel_r <= sel_r;
    end
  end

  // Result and divide-by-zero flag sampled at the closing edge of ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_r   <= 8'h00;
      div_zero_r <= 1'b0;
    end else if (latch_res_s) begin
      result_r   <= alu_result;
      div_zero_r <= (sel_r == 3'b111) && (b_r == 4'h0);
    end else begin
      result_r   <= result_r;
      div_zero_r <= div_zero_r;
    end
  end

  // Registered status strobes derived from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_valid_r  <= 1'b0;
      res_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      op_valid_r  <= (next_state_s == ISSUE);
      res_valid_r <= (next_state_s == DONE);
      busy_r      <= (next_state_s != IDLE);
    end
  end

  // Sticky overrun and wrapping op counter; a clear beats a set or an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r  <= 1'b0;
      op_count_r <= '0;
    end else if (clr_in) begin
      overrun_r  <= 1'b0;
      op_count_r <= '0;
    end else begin
      overrun_r  <= overrun_r | drop_s;
      if (count_s) begin
        op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        op_count_r <= op_count_r;
      end
    end
  end

  assign alu_a     = a_r;
  assign alu_b     = b_r;
  assign alu_sel   = sel_r;
  assign op_valid  = op_valid_r;
  assign res_valid = res_valid_r;
  assign result_q  = result_r;
  assign busy      = busy_r;
  assign div_zero  = div_zero_r;
  assign overrun   = overrun_r;
  assign op_count  = op_count_r;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: vector table, directed corner cases and
// randomized transactions checked against a transaction-level reference model.
module tb_alu_op_sequencer;

  localparam int SYNC = 2;
  localparam int CW   = 8;

  logic          clk;
  logic          rst_n;
  logic          strobe_in;
  logic [7:0]    data_in;
  logic [2:0]    op_in;
  logic          clr_in;
  logic [3:0]    alu_a;
  logic [3:0]    alu_b;
  logic [2:0]    alu_sel;
  logic [7:0]    alu_result;
  logic          op_valid;
  logic          res_valid;
  logic [7:0]    result_q;
  logic          busy;
  logic          div_zero;
  logic          overrun;
  logic [CW-1:0] op_count;

  int checks = 0;
  int errors = 0;
  int rv_cnt = 0;
  int exp_cnt = 0;
  logic [7:0] last_res = 8'h00;

  typedef struct {
    logic [7:0] data;
    logic [2:0] op;
    logic [7:0] res;
    logic       dz;
  } vec_t;
  vec_t tbl [8];

  alu_op_sequencer #(.SYNC_STAGES(SYNC), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .strobe_in(strobe_in), .data_in(data_in),
    .op_in(op_in), .clr_in(clr_in), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .alu_result(alu_result), .op_valid(op_valid),
    .res_valid(res_valid), .result_q(result_q), .busy(busy),
    .div_zero(div_zero), .overrun(overrun), .op_count(op_count)
  );

  // Bench-side ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 mul, 111 div.
  function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (sel)
      3'd0: r = ia + ib;
      3'd1: r = ia - ib;
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = ia << ib;
      3'd6: r = ia * ib;
      default: r = (ib == 0) ? 0 : ia / ib;
    endcase
    return r[7:0];
  endfunction

  function automatic logic is_chain(input logic [7:0] d, input logic [2:0] op);
`ifdef ALU_SEQ_CHAIN_EN
    return (d[3:0] == 4'hF) && op[2];
`else
    return 1'b0;
`endif
  endfunction

  assign alu_result = ref_alu(alu_a, alu_b, alu_sel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every res_valid pulse seen.
  always @(negedge clk) if (res_valid) rv_cnt <= rv_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One transaction: strobe high for 'hold' cycles, then check against the model.
  task automatic run_op(input logic [7:0] d, input logic [2:0] op, input int hold, input bit clr_at_done);
    logic [3:0] ea;
    logic [7:0] er;
    logic       edz;
    bit         seen;
    int         lat;
    ea  = is_chain(d, op) ? last_res[3:0] : d[3:0];
    er  = ref_alu(ea, d[7:4], op);
    edz = (op == 3'd7) && (d[7:4] == 4'd0);
    seen = 1'b0;
    lat  = 0;
    @(negedge clk);
    data_in = d; op_in = op; strobe_in = 1'b1;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (k >= hold) strobe_in = 1'b0;
      if (op_valid) begin
        check("alu_a", 32'(alu_a), 32'(ea));
        check("alu_b", 32'(alu_b), 32'(d[7:4]));
        check("alu_sel", 32'(alu_sel), 32'(op));
      end
      if (res_valid) begin
        seen = 1'b1;
        lat  = k;
      end
    end
    strobe_in = 1'b0;
    check("res_seen", 32'(seen), 32'd1);
    check("latency", 32'(lat), 32'(SYNC + 2));
    check("result_q", 32'(result_q), 32'(er));
    check("div_zero", 32'(div_zero), 32'(edz));
    if (clr_at_done) clr_in = 1'b1;
    @(negedge clk);
    clr_in = 1'b0;
    exp_cnt = clr_at_done ? 0 : (exp_cnt + 1) % 256;
    last_res = er;
    check("res_pulse_end", 32'(res_valid), 32'd0);
    check("busy_end", 32'(busy), 32'd0);
    check("op_count", 32'(op_count), 32'(exp_cnt));
    @(negedge clk);
  endtask

  initial begin
    int rv0;
    tbl[0] = '{8'h53, 3'd0, 8'h08, 1'b0};
    tbl[1] = '{8'h53, 3'd1, 8'hFE, 1'b0};
    tbl[2] = '{8'h0F, 3'd7, 8'h00, 1'b1};
    tbl[3] = '{8'h62, 3'd7, 8'h00, 1'b0};
    tbl[4] = '{8'h3C, 3'd6, 8'h24, 1'b0};
    tbl[5] = '{8'h35, 3'd2, 8'h01, 1'b0};
    tbl[6] = '{8'h35, 3'd4, 8'h06, 1'b0};
    tbl[7] = '{8'h35, 3'd5, 8'h28, 1'b0};

    rst_n = 1'b0; strobe_in = 1'b0; data_in = 8'h00; op_in = 3'd0; clr_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_result_q", 32'(result_q), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_flags", 32'({op_valid, res_valid, busy, div_zero, overrun}), 32'd0);
    check("rst_alu_in", 32'({alu_a, alu_b, alu_sel}), 32'd0);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].data, tbl[i].op, 1 + (i % 3), 1'b0);
      if (!is_chain(tbl[i].data, tbl[i].op)) begin
        check("tbl_result", 32'(result_q), 32'(tbl[i].res));
        check("tbl_div_zero", 32'(div_zero), 32'(tbl[i].dz));
      end
    end

    // Second strobe while busy: dropped, overrun set, one op only.
    rv0 = rv_cnt;
    @(negedge clk); data_in = 8'h53; op_in = 3'd0; strobe_in = 1'b1;
    @(negedge clk); strobe_in = 1'b0;
    @(negedge clk); strobe_in = 1'b1;
    repeat (2) @(negedge clk);
    strobe_in = 1'b0;
    repeat (6) @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    last_res = 8'h08;
    check("ovr_flag", 32'(overrun), 32'd1);
    check("ovr_one_op", 32'(rv_cnt - rv0), 32'd1);
    check("ovr_result", 32'(result_q), 32'h08);
    check("ovr_count", 32'(op_count), 32'(exp_cnt));
    clr_in = 1'b1;
    @(negedge clk); clr_in = 1'b0;
    exp_cnt = 0;
    check("clr_overrun", 32'(overrun), 32'd0);
    check("clr_count", 32'(op_count), 32'd0);

    // Clear coinciding with the DONE increment wins.
    run_op(8'h21, 3'd0, 1, 1'b0);
    run_op(8'h21, 3'd3, 2, 1'b1);

    // Reset during ISSUE aborts without a result pulse.
    run_op(8'h12, 3'd0, 1, 1'b0);
    rv0 = rv_cnt;
    @(negedge clk); data_in = 8'h53; op_in = 3'd0; strobe_in = 1'b1;
    @(negedge clk); strobe_in = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_issue", 32'(op_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_flags", 32'({op_valid, res_valid, busy, div_zero, overrun}), 32'd0);
    check("arst_result", 32'(result_q), 32'd0);
    check("arst_count", 32'(op_count), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("arst_no_res", 32'(rv_cnt - rv0), 32'd0);
    exp_cnt = 0; last_res = 8'h00;
    run_op(8'h53, 3'd0, 1, 1'b0);

    // Strobe held high for 20 cycles yields exactly one op.
    rv0 = rv_cnt;
    @(negedge clk); data_in = 8'h44; op_in = 3'd6; strobe_in = 1'b1;
    repeat (20) @(negedge clk);
    strobe_in = 1'b0;
    repeat (6) @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 256;
    last_res = 8'h10;
    check("held_one_op", 32'(rv_cnt - rv0), 32'd1);
    check("held_result", 32'(result_q), 32'h10);
    check("held_count", 32'(op_count), 32'(exp_cnt));

`ifdef ALU_SEQ_CHAIN_EN
    run_op(8'h21, 3'd0, 1, 1'b0);
    run_op(8'h4F, 3'd4, 1, 1'b0);
    check("chain_result", 32'(result_q), 32'h07);
`endif

    // 256 randomized ops after a clear: counter wraps back to zero.
    @(negedge clk); clr_in = 1'b1;
    @(negedge clk); clr_in = 1'b0;
    exp_cnt = 0;
    for (int n = 0; n < 256; n++) begin
      run_op(8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)), $urandom_range(1, 3), 1'b0);
    end
    check("wrap_count", 32'(op_count), 32'd0);
    check("wrap_overrun", 32'(overrun), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Upstream command stage for the 4-bit ALU.
- Synchronises an external load strobe and captures an operand byte and an opcode from the pad inputs.
- Issues one ALU operation, then registers the ALU result with status flags and an operation count.
- Sits between the top-level pins and the combinational ALU, and replaces free-running per-cycle operand sampling with a strobed, one-shot transaction.

Parameters:
SYNC_STAGES, 2, flops in strobe synchroniser chain (legal 2..3)
CNT_W, 8, width of op_count

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
strobe_in  in  1  asynchronous load request; each rising edge requests one op
data_in  in  8  operands: [3:0]=a, [7:4]=b
op_in  in  3  ALU select code (000 add … 111 div)
clr_in  in  1  synchronous clear of overrun and op_count
alu_a  out  4  operand a to ALU
alu_b  out  4  operand b to ALU
alu_sel  out  3  select to ALU
alu_result  in  8  combinational ALU result
op_valid  out  1  high while ALU inputs form the issued op
res_valid  out  1  one-cycle pulse: result_q/div_zero updated
result_q  out  8  registered result, held until next op
busy  out  1  high when state != IDLE
div_zero  out  1  last op was sel=111 with b=0
overrun  out  1  sticky: strobe edge dropped while busy
op_count  out  CNT_W  completed ops, wraps

Behaviour:
- Reset values: all outputs 0; state IDLE; synchroniser flops 0.
- The reset assertion is asynchronous; the reset release is used as-is and is not re-synchronised here.
- Synchroniser: strobe_in passes through SYNC_STAGES flops plus one edge-detect flop.
  - rise = last_sync & ~edge_flop, one cycle wide per strobe_in rising edge.
- The FSM has three states: IDLE, ISSUE and DONE.
  - IDLE: on rise, capture a=data_in[3:0], b=data_in[7:4], sel=op_in into operand registers, then go to ISSUE. No rise: stay.
  - ISSUE: op_valid=1, lasting one cycle. At the closing edge, result_q<=alu_result and div_zero<=(sel==3'b111 && b==0). Go to DONE.
  - DONE: res_valid=1, lasting one cycle. op_count increments (2^CNT_W-1 wraps to 0). Go to IDLE.
- alu_a, alu_b and alu_sel always drive the operand registers, so they are stable through ISSUE.
- Latency, SYNC_STAGES=2: with E0 = first clk edge sampling strobe_in high, capture occurs at E2, result_q is updated at E3, and res_valid is high E3..E4. Each extra sync stage adds one cycle.
- A rise in ISSUE or DONE is dropped and sets overrun. Operand registers are unchanged.
- Minimum accepted strobe spacing is 3 cycles after rise.
- clr_in:
  - clr_in zeroes overrun and op_count at the next edge.
  - If clr_in coincides with the DONE increment, the clear wins and op_count=0.
  - If clr_in coincides with an overrun set, the clear wins.
- strobe_in held high produces exactly one op; a new op requires a low-then-high transition.
- A reset mid-operation immediately returns to IDLE with all outputs 0. No res_valid is produced for the aborted op.
- ALU arithmetic is owned by the ALU. This block passes the full 8-bit alu_result through unmodified.

Optional Feature:
ALU_SEQ_CHAIN_EN
- Defined:
  - data_in[3:0] == 4'hF together with op_in[2] set selects chain mode.
  - In chain mode, operand a is loaded from result_q[3:0] instead of data_in[3:0]; b and sel are captured normally.
  - The previous result can thereby be accumulated.
- Undefined: data_in is always used as described above; no chain logic is present.

Test Plan:
1. Reset, then data_in=0x53, op_in=000, pulse strobe_in 4 cycles → result_q=0x08, res_valid at E3, op_count=1, div_zero=0.
2. data_in=0x53 (a=3, b=5), op_in=001 → result_q=0xFE. Then data_in=0x0F (a=15, b=0), op_in=111 → result_q=0x00, div_zero=1.
3. Second strobe rise 1 cycle after the first capture → overrun=1, op_count increments once, result_q from the first op. clr_in → overrun=0, op_count=0.
4. Assert rst_n=0 during ISSUE → outputs 0 asynchronously, no res_valid. Next strobe completes normally with op_count=1.
5. Hold strobe_in high for 20 cycles → exactly one res_valid. Run 256 ops → op_count wraps to 0.
6. (ALU_SEQ_CHAIN_EN) op add 0x21 (result_q=0x03), then data_in=0x4F, op_in=100 → a=3, b=4, result_q=0x07.
